// File: rtl/packet_deframer.sv
// packet_deframer -- bit-serial frame deframer for a BPSK receiver.
// Hunts for SYNC_WORD, then reads an 8-bit length, L payload bytes and an
// 8-bit additive checksum. Payload bytes, frame boundaries and the checksum
// result are reported as one-cycle registered strobes.
// Optional feature macro: DEFRAMER_POLARITY_EN -- also lock onto the inverted
// sync word and de-invert the rest of that frame (180-degree phase ambiguity).
module packet_deframer #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int          ERR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    // Saturating increment: the error counter sticks at all-ones.
    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + ERR_WIDTH'(1);
        end
    endfunction

    state_t                 state_r;
    logic [15:0]            hunt_r;
    logic [7:0]             shift_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             len_r;
    logic [7:0]             byte_cnt_r;
    logic [7:0]             sum_r;
    logic [7:0]             byte_out_r;
    logic                   byte_valid_r;
    logic                   frame_start_r;
    logic                   frame_done_r;
    logic                   frame_ok_r;
    logic                   locked_r;
    logic [ERR_WIDTH-1:0]   err_count_r;

    logic                   bit_s;
    logic [15:0]            hunt_next_s;
    logic [7:0]             shift_next_s;
    logic                   sync_match_s;

`ifdef DEFRAMER_POLARITY_EN
    logic                   invert_r;
    logic                   inv_match_s;

    // Field bits are de-inverted once the frame locked onto ~SYNC_WORD.
    always_comb begin
        bit_s = bit_in ^ invert_r;
    end

    // Inverted sync detection on the raw hunt window.
    always_comb begin
        inv_match_s = (hunt_next_s == ~SYNC_WORD);
    end
`else
    // Field bits are used exactly as received.
    always_comb begin
        bit_s = bit_in;
    end
`endif

    // Next hunt window (raw bits) and next field shift value (polarity-corrected).
    always_comb begin
        hunt_next_s  = {hunt_r[14:0], bit_in};
        shift_next_s = {shift_r[6:0], bit_s};
        sync_match_s = (hunt_next_s == SYNC_WORD);
    end

    // Frame FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= HUNT;
            hunt_r        <= 16'd0;
            shift_r       <= 8'd0;
            bit_cnt_r     <= 3'd0;
            len_r         <= 8'd0;
            byte_cnt_r    <= 8'd0;
            sum_r         <= 8'd0;
            byte_out_r    <= 8'd0;
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_ok_r    <= 1'b0;
            locked_r      <= 1'b0;
            err_count_r   <= '0;
`ifdef DEFRAMER_POLARITY_EN
            invert_r      <= 1'b0;
`endif
        end else begin
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_ok_r    <= 1'b0;
            if (bit_valid) begin
                case (state_r)
                    HUNT: begin
                        hunt_r <= hunt_next_s;
                        if (sync_match_s) begin
                            state_r       <= LEN;
                            frame_start_r <= 1'b1;
                            locked_r      <= 1'b1;
                            bit_cnt_r     <= 3'd0;
                            shift_r       <= 8'd0;
                        end
`ifdef DEFRAMER_POLARITY_EN
                        else if (inv_match_s) begin
                            state_r       <= LEN;
                            frame_start_r <= 1'b1;
                            locked_r      <= 1'b1;
                            bit_cnt_r     <= 3'd0;
                            shift_r       <= 8'd0;
                            invert_r      <= 1'b1;
                        end
`endif
                        else begin
                            state_r <= HUNT;
                        end
                    end
                    LEN: begin
                        shift_r   <= shift_next_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            if (shift_next_s == 8'd0) begin
                                // Empty frame counts as bad; go straight back to hunting.
                                err_count_r <= sat_inc(err_count_r);
                                state_r     <= HUNT;
                                locked_r    <= 1'b0;
                                hunt_r      <= 16'd0;
`ifdef DEFRAMER_POLARITY_EN
                                invert_r    <= 1'b0;
`endif
                            end else begin
                                len_r      <= shift_next_s;
                                sum_r      <= 8'd0;
                                byte_cnt_r <= 8'd0;
                                state_r    <= PAYLOAD;
                            end
                        end else begin
                            state_r <= LEN;
                        end
                    end
                    PAYLOAD: begin
                        shift_r   <= shift_next_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_out_r   <= shift_next_s;
                            byte_valid_r <= 1'b1;
                            sum_r        <= sum_r + shift_next_s;
                            byte_cnt_r   <= byte_cnt_r + 8'd1;
                            if ((byte_cnt_r + 8'd1) == len_r) begin
                                state_r <= CHECK;
                            end else begin
                                state_r <= PAYLOAD;
                            end
                        end else begin
                            state_r <= PAYLOAD;
                        end
                    end
                    CHECK: begin
                        shift_r   <= shift_next_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            frame_done_r <= 1'b1;
                            frame_ok_r   <= (shift_next_s == sum_r);
                            if (shift_next_s != sum_r) begin
                                err_count_r <= sat_inc(err_count_r);
                            end else begin
                                err_count_r <= err_count_r;
                            end
                            state_r  <= HUNT;
                            locked_r <= 1'b0;
                            hunt_r   <= 16'd0;
`ifdef DEFRAMER_POLARITY_EN
                            invert_r <= 1'b0;
`endif
                        end else begin
                            state_r <= CHECK;
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                        hunt_r   <= 16'd0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign byte_out    = byte_out_r;
    assign byte_valid  = byte_valid_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign frame_ok    = frame_ok_r;
    assign locked      = locked_r;
    assign err_count   = err_count_r;

endmodule

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 Parameter SYNC_WORD, default 16'hA5C3, the frame sync pattern, matched MSB first.
REQ-002 Parameter ERR_WIDTH, default 8, the width of the error counter.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bit_in  input  1  recovered bit from the BPSK receiver.
REQ-006 bit_valid  input  1  bit_in qualifier; one bit consumed per cycle with bit_valid=1; gaps of any length are legal.
REQ-007 byte_out  output  8  payload byte, MSB received first.
REQ-008 byte_valid  output  1  one-cycle strobe qualifying byte_out.
REQ-009 frame_start  output  1  one-cycle strobe on sync match.
REQ-010 frame_done  output  1  one-cycle strobe after the checksum byte.
REQ-011 frame_ok  output  1  checksum result; valid while frame_done=1, otherwise 0.
REQ-012 locked  output  1  high from sync match until the frame ends or aborts.
REQ-013 err_count  output  ERR_WIDTH  saturating count of bad frames (checksum fail or zero length).

Function
REQ-014 Frame format: SYNC_WORD (16 bits), then length L (8 bits), then L payload bytes, then checksum C (8 bits); all fields are MSB first.
REQ-015 C is the sum of the payload bytes mod 256.
REQ-016 The FSM states are HUNT, LEN, PAYLOAD and CHECK.
REQ-017 HUNT: each valid bit shifts into a 16-bit register. When the register including the current bit equals SYNC_WORD, the FSM goes to LEN and frame_start pulses in the next cycle.
REQ-018 LEN: 8 valid bits are collected as L.
  - L=0: return to HUNT, increment err_count, no frame_done.
  - Otherwise: clear the running sum and byte counter, then go to PAYLOAD.
REQ-019 PAYLOAD: every 8th valid bit completes a byte.
  - byte_out and byte_valid are registered one cycle after the completing bit.
  - Each byte is added to the running sum.
  - After byte L, go to CHECK.
REQ-020 CHECK: 8 valid bits are collected as C. One cycle after the last bit:
  - frame_done=1 and frame_ok=(C==sum).
  - err_count increments if C differs from sum.
  - The FSM returns to HUNT with the sync shift register cleared.
REQ-021 The hunt register is not updated outside HUNT; sync patterns inside a payload are ignored.
REQ-022 Bits with bit_valid=0 are ignored in every state, and the bit counter holds.
REQ-023 err_count saturates at all-ones and does not wrap.
REQ-024 byte_valid and frame_done never assert in the same cycle.
REQ-025 Fixed latency: 1 cycle from the completing bit_valid to the corresponding strobe.
REQ-026 locked=1 in LEN, PAYLOAD and CHECK; locked=0 in HUNT.

Reset
REQ-027 When reset=1 at a clock edge, the block returns to its reset state.
  - FSM goes to HUNT; shift register, bit counter, byte counter and sum are cleared.
  - All outputs are 0, including err_count.
REQ-028 Reset mid-frame aborts the frame silently: no frame_done and no err_count change.
REQ-029 Reset has priority over a simultaneous bit_valid.

Configuration
REQ-030 The macro DEFRAMER_POLARITY_EN controls handling of the BPSK 180-degree phase ambiguity.
REQ-031 With DEFRAMER_POLARITY_EN defined:
  - HUNT also matches ~SYNC_WORD.
  - On an inverted match, an internal invert flag is set and all subsequent bits of that frame are XORed with 1 before use.
  - The flag clears on return to HUNT.
  - An exact match takes precedence over an inverted one.
REQ-032 Without DEFRAMER_POLARITY_EN:
  - Only SYNC_WORD matches.
  - No invert logic is synthesised.

Verification
REQ-033 Continuous stream A5C3, 03, 54 68 69, checksum 25 -> frame_start once, then bytes 54, 68, 69, then frame_done=1 with frame_ok=1, err_count=0.
REQ-034 Same frame with checksum 26 -> three bytes, then frame_done=1 with frame_ok=0, err_count=1.
REQ-035 A5C3, 00 -> no byte_valid, no frame_done, err_count=1, locked returns to 0.
REQ-036 Bits presented with bit_valid toggling 1,0,0,1..., and a payload containing A5 C3 -> identical bytes to the continuous case; no re-sync mid-payload.
REQ-037 reset=1 after the second payload byte, then a fresh valid frame -> no frame_done for the aborted frame; the new frame decodes with err_count=0.
REQ-038 With DEFRAMER_POLARITY_EN, the bitwise-inverted stream from REQ-033 -> bytes 54, 68, 69 with frame_ok=1. Without the macro, the same stream produces no frame_start.
